burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_burst_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Line-oriented memory answering held read/write requests with four 64-bit beats after a fixed latency.
// Define BURST_MEM_PERF_EN to build the saturating completed-burst counters num_reads/num_writes.
module burst_mem_responder #(
    parameter int LINES_LOG2 = 8,
    parameter int LATENCY    = 10,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [63:0]           pmem_wdata,
    output logic [63:0]           pmem_rdata,
    output logic                  pmem_resp,
    output logic                  proto_err,
    output logic [PERF_WIDTH-1:0] num_reads,
    output logic [PERF_WIDTH-1:0] num_writes
);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    localparam int WORDS = 4 << LINES_LOG2;
    // WAIT exits when the counter reads zero, so it is loaded one short of LATENCY.
    localparam logic [7:0] WAIT_LOAD = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

    state_t                state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [LINES_LOG2-1:0] line_q, line_d;
    logic [7:0]            wait_q, wait_d;
    logic [1:0]            beat_q, beat_d;
    logic                  err_q, err_d;

    logic [63:0] mem [WORDS];

    logic req_one;
    logic req_both;
    logic req_dropped;
    logic unused_addr;

    assign req_one     = pmem_read ^ pmem_write;
    assign req_both    = pmem_read & pmem_write;
    assign req_dropped = op_write_q ? !pmem_write : !pmem_read;
    assign unused_addr = ^{pmem_address[31:LINES_LOG2+5], pmem_address[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_one) begin
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (wait_q == 8'd0) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are masked during reset so an aborted burst shows no beat in the reset cycle.
    always_comb begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (!rst && state_q == BURST) begin
            pmem_resp = 1'b1;
            if (!op_write_q) begin
                pmem_rdata = mem[{line_q, beat_q}];
            end
        end
    end

    assign proto_err = err_q & ~rst;

    always_comb begin
        op_write_d = op_write_q;
        line_d     = line_q;
        wait_d     = wait_q;
        beat_d     = beat_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_both) begin
                    err_d = 1'b1;
                end else if (req_one) begin
                    op_write_d = pmem_write;
                    line_d     = pmem_address[LINES_LOG2+4:5];
                    wait_d     = WAIT_LOAD;
                    beat_d     = 2'd0;
                end
            end
            WAIT: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end
                if (req_dropped) begin
                    err_d = 1'b1;
                end
            end
            BURST: begin
                beat_d = beat_q + 2'd1;
                if (req_dropped) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_write_q <= 1'b0;
            line_q     <= '0;
            wait_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            op_write_q <= op_write_d;
            line_q     <= line_d;
            wait_q     <= wait_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset; beats written before a reset survive it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == BURST && op_write_q) begin
            mem[{line_q, beat_q}] <= pmem_wdata;
        end
    end

`ifdef BURST_MEM_PERF_EN
    logic [PERF_WIDTH-1:0] reads_q, reads_d;
    logic [PERF_WIDTH-1:0] writes_q, writes_d;
    logic                  last_beat;

    assign last_beat = (state_q == BURST) && (beat_q == 2'd3);

    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        if (last_beat) begin
            if (op_write_q) begin
                if (writes_q != '1) begin
                    writes_d = writes_q + PERF_WIDTH'(1);
                end
            end else if (reads_q != '1) begin
                reads_d = reads_q + PERF_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
        end
    end

    assign num_reads  = rst ? '0 : reads_q;
    assign num_writes = rst ? '0 : writes_q;
`else
    assign num_reads  = '0;
    assign num_writes = '0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: one instance at LATENCY=10, one at LATENCY=0.
module tb_burst_mem_responder;

    logic        clock = 1'b0;
    logic        reset;

    logic        readReq, writeReq;
    logic [31:0] address;
    logic [63:0] writeData, readData;
    logic        respValid, protoErr;
    logic [31:0] numReads, numWrites;

    logic        readReqZ, writeReqZ;
    logic [31:0] addressZ;
    logic [63:0] writeDataZ, readDataZ;
    logic        respValidZ, protoErrZ;
    logic [31:0] numReadsZ, numWritesZ;

    int numChecks   = 0;
    int numFailures = 0;

    always #5 clock = ~clock;

    burst_mem_responder #(.LINES_LOG2(8), .LATENCY(10), .PERF_WIDTH(32)) dutMain (
        .clk(clock), .rst(reset),
        .pmem_read(readReq), .pmem_write(writeReq), .pmem_address(address),
        .pmem_wdata(writeData), .pmem_rdata(readData), .pmem_resp(respValid),
        .proto_err(protoErr), .num_reads(numReads), .num_writes(numWrites)
    );

    burst_mem_responder #(.LINES_LOG2(8), .LATENCY(0), .PERF_WIDTH(32)) dutZero (
        .clk(clock), .rst(reset),
        .pmem_read(readReqZ), .pmem_write(writeReqZ), .pmem_address(addressZ),
        .pmem_wdata(writeDataZ), .pmem_rdata(readDataZ), .pmem_resp(respValidZ),
        .proto_err(protoErrZ), .num_reads(numReadsZ), .num_writes(numWritesZ)
    );

    task automatic drive_req(input bit useZero, input logic rd, input logic wr, input logic [31:0] addr);
        if (useZero) begin
            readReqZ = rd; writeReqZ = wr; addressZ = addr;
        end else begin
            readReq = rd; writeReq = wr; address = addr;
        end
    endtask

    // Runs one well-behaved burst and reports what came back; callers do the comparing.
    task automatic run_burst(input bit useZero, input bit isWrite, input logic [31:0] addr,
                             input logic [3:0][63:0] wBeats, output logic [3:0][63:0] rBeats,
                             output int latency);
        int beat = 0;
        int cyc  = 0;
        rBeats  = '0;
        latency = -1;
        @(negedge clock);
        drive_req(useZero, !isWrite, isWrite, addr);
        while (beat < 4 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (useZero ? respValidZ : respValid) begin
                if (beat == 0) latency = cyc;
                rBeats[beat] = useZero ? readDataZ : readData;
                if (useZero) writeDataZ = wBeats[beat];
                else         writeData  = wBeats[beat];
                beat++;
            end
        end
        @(negedge clock);
        drive_req(useZero, 1'b0, 1'b0, addr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        numChecks++; if (respValid !== 1'b0) begin numFailures++; $display("[TB] FAIL reset_resp: got %b expected 0", respValid); end
        numChecks++; if (readData !== 64'd0) begin numFailures++; $display("[TB] FAIL reset_rdata: got %h expected 0", readData); end
        numChecks++; if (protoErr !== 1'b0) begin numFailures++; $display("[TB] FAIL reset_err: got %b expected 0", protoErr); end
        numChecks++; if (numReads !== 32'd0) begin numFailures++; $display("[TB] FAIL reset_reads: got %0d expected 0", numReads); end
        numChecks++; if (numWrites !== 32'd0) begin numFailures++; $display("[TB] FAIL reset_writes: got %0d expected 0", numWrites); end
        numChecks++; if (respValidZ !== 1'b0) begin numFailures++; $display("[TB] FAIL reset_resp_zero: got %b expected 0", respValidZ); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        logic [3:0][63:0] pat, got;
        int lat;
        pat[0] = 64'h1111_1111_1111_1111; pat[1] = 64'h2222_2222_2222_2222;
        pat[2] = 64'h3333_3333_3333_3333; pat[3] = 64'h4444_4444_4444_4444;
        run_burst(1'b0, 1'b1, 32'h0000_0040, pat, got, lat);
        numChecks++; if (lat !== 11) begin numFailures++; $display("[TB] FAIL write_latency: got %0d expected 11", lat); end
        run_burst(1'b0, 1'b0, 32'h0000_0040, pat, got, lat);
        numChecks++; if (lat !== 11) begin numFailures++; $display("[TB] FAIL read_latency: got %0d expected 11", lat); end
        numChecks++; if (readData !== 64'd0) begin numFailures++; $display("[TB] FAIL rdata_idle: got %h expected 0", readData); end
        for (int k = 0; k < 4; k++) begin
            numChecks++;
            if (got[k] !== pat[k]) begin numFailures++; $display("[TB] FAIL read_beat%0d: got %h expected %h", k, got[k], pat[k]); end
        end
        numChecks++; if (protoErr !== 1'b0) begin numFailures++; $display("[TB] FAIL clean_err: got %b expected 0", protoErr); end
    endtask

    task automatic test_latency_zero();
        logic [3:0][63:0] pat, got;
        int lat;
        pat[0] = 64'h0123_4567_89AB_CDEF; pat[1] = 64'hFEDC_BA98_7654_3210;
        pat[2] = 64'h0F0F_0F0F_0F0F_0F0F; pat[3] = 64'hF0F0_F0F0_F0F0_F0F0;
        run_burst(1'b1, 1'b1, 32'h0000_0040, pat, got, lat);
        run_burst(1'b1, 1'b0, 32'h0000_005F, pat, got, lat);
        numChecks++; if (lat !== 1) begin numFailures++; $display("[TB] FAIL zero_latency: got %0d expected 1", lat); end
        for (int k = 0; k < 4; k++) begin
            numChecks++;
            if (got[k] !== pat[k]) begin numFailures++; $display("[TB] FAIL zero_beat%0d: got %h expected %h", k, got[k], pat[k]); end
        end
    endtask

    task automatic test_aliasing();
        logic [3:0][63:0] pat, got;
        int lat;
        pat[0] = 64'hAAAA_0000_0000_0001; pat[1] = 64'hAAAA_0000_0000_0002;
        pat[2] = 64'hAAAA_0000_0000_0003; pat[3] = 64'hAAAA_0000_0000_0004;
        run_burst(1'b0, 1'b1, 32'h0000_2040, pat, got, lat);
        run_burst(1'b0, 1'b0, 32'h0000_0040, pat, got, lat);
        for (int k = 0; k < 4; k++) begin
            numChecks++;
            if (got[k] !== pat[k]) begin numFailures++; $display("[TB] FAIL alias_beat%0d: got %h expected %h", k, got[k], pat[k]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0][63:0] oldPat, newPat, want, got;
        int lat;
        int beat = 0;
        int cyc  = 0;
        bit hitBeat2 = 1'b0;
        oldPat[0] = 64'hC0C0_0000_0000_0000; oldPat[1] = 64'hC0C0_1111_1111_1111;
        oldPat[2] = 64'hC0C0_2222_2222_2222; oldPat[3] = 64'hC0C0_3333_3333_3333;
        newPat[0] = 64'hD0D0_0000_0000_0000; newPat[1] = 64'hD0D0_1111_1111_1111;
        newPat[2] = 64'hD0D0_2222_2222_2222; newPat[3] = 64'hD0D0_3333_3333_3333;
        run_burst(1'b0, 1'b1, 32'h0000_0080, oldPat, got, lat);
        @(negedge clock);
        drive_req(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        while (!hitBeat2 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (respValid) begin
                writeData = newPat[beat];
                if (beat == 2) begin
                    reset    = 1'b1;
                    hitBeat2 = 1'b1;
                end
                beat++;
            end
        end
        numChecks++; if (hitBeat2 !== 1'b1) begin numFailures++; $display("[TB] FAIL abort_reach_beat2: got %b expected 1", hitBeat2); end
        @(negedge clock);
        numChecks++; if (respValid !== 1'b0) begin numFailures++; $display("[TB] FAIL abort_resp: got %b expected 0", respValid); end
        reset = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0000_0080);
        want[0] = newPat[0]; want[1] = newPat[1]; want[2] = oldPat[2]; want[3] = oldPat[3];
        run_burst(1'b0, 1'b0, 32'h0000_0080, want, got, lat);
        numChecks++; if (lat !== 11) begin numFailures++; $display("[TB] FAIL abort_idle_latency: got %0d expected 11", lat); end
        for (int k = 0; k < 4; k++) begin
            numChecks++;
            if (got[k] !== want[k]) begin numFailures++; $display("[TB] FAIL abort_beat%0d: got %h expected %h", k, got[k], want[k]); end
        end
    endtask

    task automatic test_both_requests();
        bit sawResp = 1'b0;
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (respValid) sawResp = 1'b1;
        end
        numChecks++; if (sawResp !== 1'b0) begin numFailures++; $display("[TB] FAIL both_no_resp: got %b expected 0", sawResp); end
        numChecks++; if (protoErr !== 1'b1) begin numFailures++; $display("[TB] FAIL both_err: got %b expected 1", protoErr); end
        drive_req(1'b0, 1'b0, 1'b0, 32'h0000_0040);
        repeat (3) @(negedge clock);
        numChecks++; if (protoErr !== 1'b1) begin numFailures++; $display("[TB] FAIL both_err_sticky: got %b expected 1", protoErr); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        numChecks++; if (protoErr !== 1'b0) begin numFailures++; $display("[TB] FAIL both_err_cleared: got %b expected 0", protoErr); end
    endtask

    task automatic test_early_drop();
        int beats = 0;
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_00C0);
        @(negedge clock);
        drive_req(1'b0, 1'b0, 1'b0, 32'h0000_00C0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (respValid) beats++;
        end
        numChecks++; if (beats !== 4) begin numFailures++; $display("[TB] FAIL drop_beats: got %0d expected 4", beats); end
        numChecks++; if (protoErr !== 1'b1) begin numFailures++; $display("[TB] FAIL drop_err: got %b expected 1", protoErr); end
    endtask

    task automatic test_perf_counters();
        logic [3:0][63:0] pat, got;
        int lat;
        logic [31:0] expReads, expWrites;
`ifdef BURST_MEM_PERF_EN
        expReads  = 32'd3;
        expWrites = 32'd2;
`else
        expReads  = 32'd0;
        expWrites = 32'd0;
`endif
        pat[0] = 64'h5; pat[1] = 64'h6; pat[2] = 64'h7; pat[3] = 64'h8;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        run_burst(1'b0, 1'b1, 32'h0000_0100, pat, got, lat);
        run_burst(1'b0, 1'b0, 32'h0000_0100, pat, got, lat);
        run_burst(1'b0, 1'b1, 32'h0000_0120, pat, got, lat);
        run_burst(1'b0, 1'b0, 32'h0000_0120, pat, got, lat);
        run_burst(1'b0, 1'b0, 32'h0000_0100, pat, got, lat);
        @(negedge clock);
        numChecks++; if (numReads !== expReads) begin numFailures++; $display("[TB] FAIL perf_reads: got %0d expected %0d", numReads, expReads); end
        numChecks++; if (numWrites !== expWrites) begin numFailures++; $display("[TB] FAIL perf_writes: got %0d expected %0d", numWrites, expWrites); end
        numChecks++; if (protoErr !== 1'b0) begin numFailures++; $display("[TB] FAIL perf_err: got %b expected 0", protoErr); end
    endtask

    initial begin
        reset = 1'b1;
        readReq = 1'b0; writeReq = 1'b0; address = '0; writeData = '0;
        readReqZ = 1'b0; writeReqZ = 1'b0; addressZ = '0; writeDataZ = '0;
        test_reset();
        test_write_read();
        test_latency_zero();
        test_aliasing();
        test_reset_abort();
        test_both_requests();
        test_early_drop();
        test_perf_counters();
        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
        $finish;
    end

endmodule
